// File: rtl/kernel_2mm_call_pkg.sv
// rtl/kernel_2mm_call_pkg.sv - shared widths, FSM state and timestamp entry for the kernel_2mm call driver
package kernel_2mm_call_pkg;
  localparam int SCALAR_W = 32;
  localparam int PTR_W    = 64;
  localparam int SEQ_W    = 8;
  localparam int STAMP_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALL = 1'b1
  } state_t;

  typedef struct packed {
    logic [STAMP_W-1:0] ts;
    logic [SEQ_W-1:0]   seq;
  } ts_entry_t;
endpackage

// File: rtl/hls_ts_fifo.sv
// rtl/hls_ts_fifo.sv - register FIFO of call timestamps; head is combinational, push and pop may coincide
module hls_ts_fifo
  import kernel_2mm_call_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  ts_entry_t push_data,
  input  logic      pop,
  output ts_entry_t pop_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ts_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // explicit wrap keeps DEPTH=1 legal with a 1-bit pointer
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
    end
  end
endmodule

// File: rtl/kernel_2mm_call_driver.sv
// rtl/kernel_2mm_call_driver.sv - caller-side driver of the kernel_2mm call/return interface
module kernel_2mm_call_driver
  import kernel_2mm_call_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TS_W            = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [SCALAR_W-1:0]              cmd_alpha,
  input  logic [SCALAR_W-1:0]              cmd_beta,
  input  logic [PTR_W-1:0]                 cmd_a,
  input  logic [PTR_W-1:0]                 cmd_b,
  input  logic [PTR_W-1:0]                 cmd_c,
  input  logic [PTR_W-1:0]                 cmd_d,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [SEQ_W-1:0]                 rsp_seq,
  output logic [TS_W-1:0]                  rsp_latency,
  output logic                             k_start,
  input  logic                             k_busy,
  output logic [SCALAR_W-1:0]              k_alpha,
  output logic [SCALAR_W-1:0]              k_beta,
  output logic [PTR_W-1:0]                 k_A,
  output logic [PTR_W-1:0]                 k_B,
  output logic [PTR_W-1:0]                 k_C,
  output logic [PTR_W-1:0]                 k_D,
  input  logic                             k_done,
  output logic                             k_stall,
  output logic                             idle,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_spurious
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  state_t           state;
  logic [SEQ_W-1:0] seq;
  logic [TS_W-1:0]  ts_now;
  ts_entry_t        push_entry;
  ts_entry_t        head;
  logic             cmd_fire;
  logic             call_acc;
  logic             ret_acc;
  logic             pop;

  assign k_start   = (state == CALL);
  assign cmd_ready = ~reset & (state == IDLE) & (outstanding < OW'(MAX_OUTSTANDING));
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign call_acc  = k_start & ~k_busy;
  assign k_stall   = rsp_valid & ~rsp_ready;
  assign ret_acc   = k_done & ~k_stall;
  // a return with nothing in flight is swallowed and flagged instead of popping
  assign pop       = ret_acc & (outstanding != '0);
  assign idle      = (state == IDLE) & (outstanding == '0) & ~rsp_valid;

  always_comb begin
    push_entry     = '0;
    push_entry.ts  = STAMP_W'(ts_now);
    push_entry.seq = seq;
  end

  hls_ts_fifo #(.DEPTH(MAX_OUTSTANDING)) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (call_acc),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      seq          <= '0;
      ts_now       <= '0;
      outstanding  <= '0;
      k_alpha      <= '0;
      k_beta       <= '0;
      k_A          <= '0;
      k_B          <= '0;
      k_C          <= '0;
      k_D          <= '0;
      rsp_valid    <= 1'b0;
      rsp_seq      <= '0;
      rsp_latency  <= '0;
      err_spurious <= 1'b0;
    end else begin
      ts_now <= ts_now + 1'b1;

      if (cmd_fire) begin
        k_alpha <= cmd_alpha;
        k_beta  <= cmd_beta;
        k_A     <= cmd_a;
        k_B     <= cmd_b;
        k_C     <= cmd_c;
        k_D     <= cmd_d;
        state   <= CALL;
      end else if (call_acc) begin
        state <= IDLE;
      end

      if (call_acc) seq <= seq + 1'b1;

      if (call_acc & ~pop)      outstanding <= outstanding + 1'b1;
      else if (pop & ~call_acc) outstanding <= outstanding - 1'b1;

      // a new return may land in the same cycle the previous response is taken
      if (pop) begin
        rsp_valid   <= 1'b1;
        rsp_seq     <= head.seq;
        rsp_latency <= ts_now - head.ts[TS_W-1:0];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (ret_acc & ~pop) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kernel_2mm_call_driver.sv
// tb/tb_kernel_2mm_call_driver.sv - randomized scoreboard bench for kernel_2mm_call_driver
module tb_kernel_2mm_call_driver;
  localparam int MAXO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, rsp_ready = 1'b1, k_busy = 1'b0, k_done = 1'b0;
  logic [31:0] cmd_alpha = '0, cmd_beta = '0;
  logic [63:0] cmd_a = '0, cmd_b = '0, cmd_c = '0, cmd_d = '0;
  logic        cmd_ready, rsp_valid, k_start, k_stall, idle, err_spurious;
  logic [7:0]  rsp_seq;
  logic [31:0] rsp_latency, k_alpha, k_beta;
  logic [63:0] k_A, k_B, k_C, k_D;
  logic [2:0]  outstanding;

  always #5 clock = ~clock;

  kernel_2mm_call_driver #(.MAX_OUTSTANDING(MAXO), .TS_W(32)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_alpha(cmd_alpha), .cmd_beta(cmd_beta), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_c(cmd_c), .cmd_d(cmd_d), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_seq(rsp_seq), .rsp_latency(rsp_latency), .k_start(k_start), .k_busy(k_busy),
    .k_alpha(k_alpha), .k_beta(k_beta), .k_A(k_A), .k_B(k_B), .k_C(k_C), .k_D(k_D),
    .k_done(k_done), .k_stall(k_stall), .idle(idle), .outstanding(outstanding),
    .err_spurious(err_spurious)
  );

  typedef struct { logic [31:0] cyc; logic [7:0] seq; } call_t;
  typedef struct { logic [7:0] seq; logic [31:0] lat; } rsp_t;

  call_t       calls[$];
  rsp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = '0;
  logic        m_pending = 1'b0, m_rsp_valid = 1'b0, m_err = 1'b0;
  logic [7:0]  m_seq = '0;
  logic [31:0] m_alpha = '0, m_beta = '0;
  logic [63:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
  logic [7:0]  last_seq = 8'hFF;
  logic [31:0] last_lat = '1;
  int          start_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: call and return events tracked as cycle numbers and queues
  always @(negedge clock) begin : model
    logic  exp_ready, exp_stall, call_acc, ret_acc, took;
    call_t c;
    rsp_t  r;
    exp_ready = !reset && !m_pending && (calls.size() < MAXO);
    exp_stall = m_rsp_valid && !rsp_ready;
    check("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
    check("k_start", 64'(k_start), 64'(m_pending));
    check("k_stall", 64'(k_stall), 64'(exp_stall));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
    check("outstanding", 64'(outstanding), 64'(calls.size()));
    check("idle", 64'(idle), 64'(!m_pending && calls.size() == 0 && !m_rsp_valid));
    check("err_spurious", 64'(err_spurious), 64'(m_err));
    if (m_pending) begin
      check("k_alpha", 64'(k_alpha), 64'(m_alpha));
      check("k_beta", 64'(k_beta), 64'(m_beta));
      check("k_A", k_A, m_a);
      check("k_B", k_B, m_b);
      check("k_C", k_C, m_c);
      check("k_D", k_D, m_d);
    end
    call_acc = m_pending && !k_busy;
    ret_acc  = k_done && !exp_stall;
    took     = 1'b0;
    if (ret_acc) begin
      if (calls.size() > 0) begin
        c = calls.pop_front();
        r.seq = c.seq;
        r.lat = cyc - c.cyc;
        exp_q.push_back(r);
        took = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (took) m_rsp_valid = 1'b1;
    else if (rsp_ready) m_rsp_valid = 1'b0;
    if (call_acc) begin
      c.cyc = cyc;
      c.seq = m_seq;
      calls.push_back(c);
      m_seq++;
      m_pending = 1'b0;
    end
    if (cmd_valid && exp_ready) begin
      m_pending = 1'b1;
      m_alpha = cmd_alpha; m_beta = cmd_beta;
      m_a = cmd_a; m_b = cmd_b; m_c = cmd_c; m_d = cmd_d;
    end
    if (reset) begin
      m_pending = 1'b0; m_rsp_valid = 1'b0; m_err = 1'b0; m_seq = '0;
      calls.delete();
    end
    cyc++;
  end

  always @(negedge clock) begin : monitor
    rsp_t e;
    if (k_start === 1'b1) start_cnt++;
    if (rsp_valid === 1'b1 && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got seq %0d latency %0d, expected no response", rsp_seq, rsp_latency);
      end else begin
        e = exp_q.pop_front();
        check("rsp_seq", 64'(rsp_seq), 64'(e.seq));
        check("rsp_latency", 64'(rsp_latency), 64'(e.lat));
      end
      last_seq = rsp_seq;
      last_lat = rsp_latency;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rand_args();
    cmd_alpha = $urandom; cmd_beta = $urandom;
    cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
    cmd_c = {$urandom, $urandom}; cmd_d = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; cmd_valid = 1'b0; k_done = 1'b0; k_busy = 1'b0; rsp_ready = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  // ends one cycle after the call is accepted (busy low)
  task automatic issue_call();
    cmd_valid = 1'b1; rand_args();
    step(1);
    cmd_valid = 1'b0;
    step(1);
  endtask

  task automatic drain();
    int lim = 60;
    while (calls.size() > 0 && lim > 0) begin
      k_done = 1'b1;
      step(1);
      lim--;
    end
    k_done = 1'b0;
    if (lim == 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d calls still outstanding, expected 0", calls.size());
    end
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    // reset state
    step(3);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_k_start", 64'(k_start), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    reset = 1'b0;

    // 1: single call, done 10 cycles after accept
    s0 = start_cnt;
    issue_call();
    step(9);
    k_done = 1'b1; step(1); k_done = 1'b0;
    step(3);
    check("t1_latency", 64'(last_lat), 64'd10);
    check("t1_seq", 64'(last_seq), 64'd0);
    check("t1_start_cycles", 64'(start_cnt - s0), 64'd1);
    check("t1_idle", 64'(idle), 64'd1);

    // 2: busy for 5 cycles while calling
    s0 = start_cnt;
    cmd_valid = 1'b1; k_busy = 1'b1; rand_args();
    step(1);
    cmd_valid = 1'b0;
    step(5);
    k_busy = 1'b0;
    step(1);
    check("t2_start_cycles", 64'(start_cnt - s0), 64'd6);
    drain();

    // 3: fill to MAX_OUTSTANDING, one done frees a slot
    do_reset(2);
    cmd_valid = 1'b1;
    repeat (12) begin rand_args(); step(1); end
    check("t3_outstanding_full", 64'(outstanding), 64'd4);
    check("t3_cmd_ready_full", 64'(cmd_ready), 64'd0);
    k_done = 1'b1; step(1); k_done = 1'b0;
    repeat (4) begin rand_args(); step(1); end
    cmd_valid = 1'b0;
    step(2);
    check("t3_outstanding_refill", 64'(outstanding), 64'd4);
    drain();
    check("t3_last_seq", 64'(last_seq), 64'd4);

    // 4: response backpressure with done held high
    issue_call();
    issue_call();
    rsp_ready = 1'b0; k_done = 1'b1;
    step(6);
    check("t4_k_stall", 64'(k_stall), 64'd1);
    check("t4_outstanding", 64'(outstanding), 64'd1);
    rsp_ready = 1'b1;
    drain();

    // 5: call accept and return accept in the same cycle
    issue_call();
    issue_call();
    cmd_valid = 1'b1; rand_args();
    step(1);
    cmd_valid = 1'b0; k_done = 1'b1;
    step(1);
    k_done = 1'b0;
    check("t5_outstanding", 64'(outstanding), 64'd2);
    drain();

    // random traffic
    repeat (400) begin
      cmd_valid = 1'($urandom_range(1, 0));
      rand_args();
      k_busy    = ($urandom_range(3, 0) == 0);
      k_done    = ($urandom_range(3, 0) == 0);
      rsp_ready = ($urandom_range(3, 0) != 0);
      step(1);
    end
    cmd_valid = 1'b0; k_busy = 1'b0; k_done = 1'b0; rsp_ready = 1'b1;
    step(2);
    drain();

    // 6: timestamp wrap, spurious done, reset during CALL
    do_reset(2);
    @(negedge clock);
    force dut.ts_now = 32'hFFFF_FFFD;
    #1;
    release dut.ts_now;
    @(posedge clock); #1;
    issue_call();
    step(6);
    k_done = 1'b1; step(1); k_done = 1'b0;
    step(3);
    check("t6_wrap_latency", 64'(last_lat), 64'd7);
    k_done = 1'b1; step(1); k_done = 1'b0;
    step(2);
    check("t6_err_set", 64'(err_spurious), 64'd1);
    step(3);
    check("t6_err_sticky", 64'(err_spurious), 64'd1);
    cmd_valid = 1'b1; k_busy = 1'b1; rand_args();
    step(1);
    cmd_valid = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    check("t6_rst_k_start", 64'(k_start), 64'd0);
    check("t6_rst_err", 64'(err_spurious), 64'd0);
    check("t6_rst_idle", 64'(idle), 64'd1);
    check("t6_rst_k_alpha", 64'(k_alpha), 64'd0);
    reset = 1'b0; k_busy = 1'b0;
    step(2);
    check("t6_post_idle", 64'(idle), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
